// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI write master.
package oled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        NEXT,
        HOLD,
        GAP
    } oled_spi_state_t;

    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

endpackage

// File: rtl/oled_spi_tick.sv
// Divider for the serial clock: strobes phase_done once every CLK_DIV enabled cycles.
module oled_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic phase_done
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign phase_done = enable && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || phase_done) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/oled_spi_master.sv
// SPI mode-0 write master for the RGB OLED panel: valid/ready word stream in,
// CS/SCLK/MOSI/DC out, with chip select held low across multi-word bursts.
module oled_spi_master
    import oled_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int MSB_FIRST  = 1,
    parameter int CS_GAP     = 2
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sdata,
    input  logic                  sdata_dc,
    input  logic                  sdata_last,
    input  logic                  sdata_valid,
    output logic                  ready,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic                  dc,
    output logic                  cs,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = $clog2(CS_GAP + 1);

    oled_spi_state_t       state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  last;
    logic                  dc_q;
    logic                  start;
    logic                  accept;
    logic                  tick_en;
    logic                  phase_done;
    logic                  first_bit;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] shreg_shifted;

    assign accept        = sdata_valid && ready;
    assign tick_en       = ((state == SHIFT) && !start) || (state == HOLD);
    assign first_bit     = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
    assign next_bit      = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-2] : shreg[1];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[DATA_WIDTH-1:1]};

    oled_spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .restart   (start),
        .enable    (tick_en),
        .phase_done(phase_done)
    );

    // NOTE: every register here is assigned with <= so all updates in one edge
    // see the pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b0;
            cs      <= 1'b1;
            spi_clk <= 1'b0;
            mosi    <= 1'b0;
            dc      <= OLED_DC_CMD;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            last    <= 1'b0;
            dc_q    <= OLED_DC_CMD;
            start   <= 1'b0;
        end else begin
            case (state)
                IDLE, NEXT: begin
                    ready <= 1'b1;
                    if (accept) begin
                        state   <= SHIFT;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        start   <= 1'b1;
                        shreg   <= sdata;
                        dc_q    <= sdata_dc;
                        last    <= sdata_last;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // The cycle after accept drives the pins; the divider starts from it.
                    if (start) begin
                        start   <= 1'b0;
                        cs      <= 1'b0;
                        dc      <= dc_q;
                        spi_clk <= 1'b0;
                        mosi    <= first_bit;
                    end else if (phase_done) begin
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                state <= last ? HOLD : NEXT;
                                ready <= !last;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                shreg   <= shreg_shifted;
                                mosi    <= next_bit;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        state   <= GAP;
                        cs      <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(CS_GAP - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_master.sv
// Self-checking bench for oled_spi_master: table of word/burst vectors on an
// 8-bit MSB-first instance, plus LSB-first 16-bit and mid-word reset sequences.
module tb_oled_spi_master;
    import oled_pkg::*;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    logic [7:0]  a_sdata = '0;
    logic        a_dc_in = 1'b0, a_last = 1'b0, a_valid = 1'b0;
    logic        a_ready, a_spi_clk, a_mosi, a_dc, a_cs, a_busy;
    logic [15:0] b_sdata = '0;
    logic        b_dc_in = 1'b0, b_last = 1'b0, b_valid = 1'b0;
    logic        b_ready, b_spi_clk, b_mosi, b_dc, b_cs, b_busy;

    oled_spi_master #(.DATA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1), .CS_GAP(2)) dut_a (
        .sclk(sclk), .rst_n(rst_n), .sdata(a_sdata), .sdata_dc(a_dc_in),
        .sdata_last(a_last), .sdata_valid(a_valid), .ready(a_ready),
        .spi_clk(a_spi_clk), .mosi(a_mosi), .dc(a_dc), .cs(a_cs), .busy(a_busy)
    );

    oled_spi_master #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(0), .CS_GAP(2)) dut_b (
        .sclk(sclk), .rst_n(rst_n), .sdata(b_sdata), .sdata_dc(b_dc_in),
        .sdata_last(b_last), .sdata_valid(b_valid), .ready(b_ready),
        .spi_clk(b_spi_clk), .mosi(b_mosi), .dc(b_dc), .cs(b_cs), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        string          name;
        logic [2:0][7:0] words;
        logic           dc;
        int             nwords;
        int             stall;
        bit             junk;
        int             cycles;
        logic [31:0]    exp_seq;
        int             exp_rises;
        int             exp_cs_rise;
        int             exp_ready_rise;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [2:0][7:0] words, input logic dc,
                                input int nwords, input int stall, input bit junk, input int cycles,
                                input logic [31:0] exp_seq, input int exp_rises,
                                input int exp_cs_rise, input int exp_ready_rise);
        vec_t v;
        v.name = name; v.words = words; v.dc = dc; v.nwords = nwords; v.stall = stall;
        v.junk = junk; v.cycles = cycles; v.exp_seq = exp_seq; v.exp_rises = exp_rises;
        v.exp_cs_rise = exp_cs_rise; v.exp_ready_rise = exp_ready_rise;
        return v;
    endfunction

    // Observations gathered by run_a, relative to the first accept edge (cycle 0).
    int          rises, first_rise, cs_rise, ready_rise, cs_rises, dc_bad, mosi_bad, stall_bad;
    logic [31:0] seq;
    logic        busy1;

    task automatic run_a(input vec_t v);
        int   idx, cyc, stall_left;
        bit   send;
        logic prev_clk, prev_mosi, prev_cs;
        idx = 0; cyc = -1; stall_left = v.stall;
        rises = 0; first_rise = -1; cs_rise = -1; ready_rise = -1; cs_rises = 0;
        dc_bad = 0; mosi_bad = 0; stall_bad = 0; seq = '0; busy1 = 1'b0;
        prev_clk = a_spi_clk; prev_mosi = a_mosi; prev_cs = a_cs;
        for (int n = 0; n < v.cycles; n++) begin
            send = 1'b0;
            if (idx < v.nwords && a_ready) begin
                if (idx > 0 && stall_left > 0) begin
                    stall_left--;
                    if (a_cs !== 1'b0 || a_spi_clk !== 1'b0) stall_bad++;
                end else begin
                    send = 1'b1;
                end
            end
            if (send) begin
                a_valid = 1'b1; a_sdata = v.words[idx]; a_dc_in = v.dc;
                a_last = (idx == v.nwords - 1);
            end else if (v.junk && !a_ready) begin
                a_valid = n[0]; a_sdata = 8'($urandom); a_dc_in = ~v.dc;
                a_last = 1'($urandom_range(0, 1));
            end else begin
                a_valid = 1'b0;
            end
            @(posedge sclk); #1;
            cyc++;
            if (send) idx++;
            if (!prev_clk && a_spi_clk) begin
                rises++;
                seq = {seq[30:0], a_mosi};
                if (first_rise < 0) first_rise = cyc;
            end
            if (prev_clk && a_spi_clk && a_mosi !== prev_mosi) mosi_bad++;
            if (a_cs === 1'b0 && a_dc !== v.dc) dc_bad++;
            if (prev_cs === 1'b0 && a_cs === 1'b1) begin
                cs_rises++;
                if (cs_rise < 0) cs_rise = cyc;
            end
            if (cs_rise >= 0 && ready_rise < 0 && a_ready) ready_rise = cyc;
            if (cyc == 1) busy1 = a_busy && !a_cs && !a_spi_clk;
            prev_clk = a_spi_clk; prev_mosi = a_mosi; prev_cs = a_cs;
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_ready(input bit which_b);
        for (int i = 0; i < 200; i++) begin
            if ((which_b ? b_ready : a_ready) === 1'b1) return;
            @(posedge sclk); #1;
        end
        check(which_b ? "b_ready_timeout" : "a_ready_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        int          b_rises, b_first, b_last_rise, b_cs_rise, b_ready_rise, hrun, hmax;
        logic [31:0] b_seq;
        logic        b_prev_clk, b_prev_cs;

        vecs[0] = mk("cmd_a5",   {8'h00, 8'h00, 8'hA5}, OLED_DC_CMD,  1, 0,  0, 45,  32'hA5,     8,  35,  37);
        vecs[1] = mk("data_3c",  {8'h00, 8'h00, 8'h3C}, OLED_DC_DATA, 1, 0,  1, 45,  32'h3C,     8,  35,  37);
        vecs[2] = mk("data_00",  {8'h00, 8'h00, 8'h00}, OLED_DC_DATA, 1, 0,  0, 45,  32'h00,     8,  35,  37);
        vecs[3] = mk("cmd_ff",   {8'h00, 8'h00, 8'hFF}, OLED_DC_CMD,  1, 0,  1, 45,  32'hFF,     8,  35,  37);
        vecs[4] = mk("burst3",   {8'h56, 8'h34, 8'h12}, OLED_DC_DATA, 3, 0,  1, 112, 32'h123456, 24, 103, 105);
        vecs[5] = mk("stall50",  {8'h00, 8'hCD, 8'hAB}, OLED_DC_DATA, 2, 50, 0, 130, 32'hABCD,   16, 119, 121);

        // Reset state and first edge after release.
        repeat (2) @(posedge sclk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_ready_a", a_ready, 0);
        check("rst_ready_b", b_ready, 0);
        check("rst_cs_a", a_cs, 1);
        check("rst_busy_a", a_busy, 0);
        @(posedge sclk); #1;
        check("rel_ready_a", a_ready, 1);
        check("rel_ready_b", b_ready, 1);

        for (int i = 0; i < 6; i++) begin
            wait_ready(1'b0);
            run_a(vecs[i]);
            check({vecs[i].name, "_seq"},        seq,        vecs[i].exp_seq);
            check({vecs[i].name, "_rises"},      rises,      vecs[i].exp_rises);
            check({vecs[i].name, "_first_rise"}, first_rise, 3);
            check({vecs[i].name, "_cs_rise"},    cs_rise,    vecs[i].exp_cs_rise);
            check({vecs[i].name, "_ready_rise"}, ready_rise, vecs[i].exp_ready_rise);
            check({vecs[i].name, "_cs_rises"},   cs_rises,   1);
            check({vecs[i].name, "_dc_bad"},     dc_bad,     0);
            check({vecs[i].name, "_mosi_bad"},   mosi_bad,   0);
            check({vecs[i].name, "_stall_bad"},  stall_bad,  0);
            check({vecs[i].name, "_busy1"},      busy1,      1);
        end

        // LSB-first 16-bit word with H=1.
        wait_ready(1'b1);
        b_sdata = 16'h8001; b_dc_in = OLED_DC_DATA; b_last = 1'b1; b_valid = 1'b1;
        @(posedge sclk); #1;
        b_valid = 1'b0;
        b_rises = 0; b_first = -1; b_last_rise = -1; b_cs_rise = -1; b_ready_rise = -1;
        hrun = 0; hmax = 0; b_seq = '0;
        b_prev_clk = b_spi_clk; b_prev_cs = b_cs;
        for (int c = 1; c <= 40; c++) begin
            @(posedge sclk); #1;
            if (!b_prev_clk && b_spi_clk) begin
                b_rises++;
                b_seq = {b_seq[30:0], b_mosi};
                if (b_first < 0) b_first = c;
                b_last_rise = c;
            end
            hrun = b_spi_clk ? hrun + 1 : 0;
            if (hrun > hmax) hmax = hrun;
            if (b_prev_cs === 1'b0 && b_cs === 1'b1 && b_cs_rise < 0) b_cs_rise = c;
            if (b_cs_rise >= 0 && b_ready_rise < 0 && b_ready) b_ready_rise = c;
            b_prev_clk = b_spi_clk; b_prev_cs = b_cs;
        end
        check("lsb16_seq",        b_seq,        32'h8001);
        check("lsb16_rises",      b_rises,      16);
        check("lsb16_first_rise", b_first,      2);
        check("lsb16_last_rise",  b_last_rise,  32);
        check("lsb16_high_width", hmax,         1);
        check("lsb16_cs_rise",    b_cs_rise,    34);
        check("lsb16_ready_rise", b_ready_rise, 36);

        // Reset asserted mid-word during bit 3's high phase.
        wait_ready(1'b0);
        a_sdata = 8'hFF; a_dc_in = OLED_DC_DATA; a_last = 1'b1; a_valid = 1'b1;
        @(posedge sclk); #1;
        a_valid = 1'b0;
        repeat (15) @(posedge sclk);
        #1;
        check("mid_spi_clk", a_spi_clk, 1);
        check("mid_mosi",    a_mosi,    1);
        check("mid_cs",      a_cs,      0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs",      a_cs,      1);
        check("arst_spi_clk", a_spi_clk, 0);
        check("arst_mosi",    a_mosi,    0);
        check("arst_ready",   a_ready,   0);
        check("arst_busy",    a_busy,    0);
        check("arst_dc",      a_dc,      0);
        repeat (2) @(posedge sclk);
        #2 rst_n = 1'b1;
        #1;
        check("arst_rel_ready_before", a_ready, 0);
        @(posedge sclk); #1;
        check("arst_rel_ready_after", a_ready, 1);
        check("arst_rel_cs",          a_cs,    1);
        repeat (40) @(posedge sclk);
        #1;
        check("arst_no_resume_cs", a_cs, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
